// File: rtl/mg_tx_arbiter.sv
// Frame-level arbiter for the shared 128-bit transceiver TX path: urgent-first,
// round-robin within class, whole-frame lock, one output register stage, stall timeout.
module mg_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 128,
  parameter int STALL_MAX = 15
) (
  input  logic                      tx_clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ-1:0]        req_urgent,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_enable,
  output logic [DATA_W-1:0]         tx_data_out,
  output logic                      tx_valid_out,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      stall_abort,
  output logic [31:0]               frame_count
);

  localparam int                 IDX_W       = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]     NREQ_W      = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]         STALL_LIMIT = 8'(STALL_MAX);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        g_q;
  logic [IDX_W-1:0]        rr_ptr;
  logic [7:0]              stall_cnt;

  logic                    g_valid, g_last;
  logic [DATA_W-1:0]       g_data;
  logic                    accept;
  logic [NUM_REQ-1:0]      cand;
  logic [2*NUM_REQ-1:0]    cand2;
  logic [IDX_W:0]          pos;
  logic [IDX_W-1:0]        winner;
  logic                    found;
  logic                    do_grant, do_abort, frame_done, stall_inc;

  assign grant_id = 3'(g_q);
  assign busy     = (state == LOCK);
  assign accept   = busy && tx_enable && g_valid;

  // Constant-index mux of the locked requester's signals.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_q == IDX_W'(i)) begin
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        g_data       = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = busy && tx_enable;
      end
    end
  end

  // Urgent class masks normal requesters; search starts at rr_ptr over a doubled vector to wrap.
  always_comb begin
    cand   = (|(req_valid & req_urgent)) ? (req_valid & req_urgent) : req_valid;
    cand2  = {cand, cand};
    pos    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (!found && cand2[pos]) begin
        found  = 1'b1;
        winner = (pos >= NREQ_W) ? IDX_W'(pos - NREQ_W) : IDX_W'(pos);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_abort   = 1'b0;
    frame_done = 1'b0;
    stall_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable && found) begin
          state_nxt = LOCK;
          do_grant  = 1'b1;
        end
      end
      LOCK: begin
        // A beat offered alongside the timeout is still taken, never dropped.
        if (accept) begin
          if (g_last) begin
            state_nxt  = IDLE;
            frame_done = 1'b1;
          end
        end else if (stall_cnt == STALL_LIMIT) begin
          state_nxt = IDLE;
          do_abort  = 1'b1;
        end else if (tx_enable && !g_valid) begin
          stall_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      g_q          <= '0;
      rr_ptr       <= '0;
      stall_cnt    <= '0;
      stall_abort  <= 1'b0;
      frame_count  <= '0;
      tx_valid_out <= 1'b0;
      tx_data_out  <= '0;
    end else begin
      state        <= state_nxt;
      stall_abort  <= do_abort;
      tx_valid_out <= accept;
      if (accept)
        tx_data_out <= g_data;
      if (frame_done)
        frame_count <= frame_count + 32'd1;
      if (do_grant) begin
        g_q    <= winner;
        rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
      end
      if (do_grant || accept || do_abort)
        stall_cnt <= '0;
      else if (stall_inc)
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mg_tx_arbiter.sv
// Directed bench for mg_tx_arbiter: requester model plus grant/data scoreboards
// filled with the predicted order and drained as the arbiter produces output.
module tb_mg_tx_arbiter;

  localparam int N = 4;
  localparam int W = 128;

  logic           tx_clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid, req_last, req_urgent, req_ready;
  logic           tx_enable;
  logic [W-1:0]   tx_data_out;
  logic           tx_valid_out;
  logic [2:0]     grant_id;
  logic           busy, stall_abort;
  logic [31:0]    frame_count;

  mg_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .STALL_MAX(15)) dut (
    .tx_clk      (tx_clk),
    .reset       (reset),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_urgent  (req_urgent),
    .req_ready   (req_ready),
    .tx_enable   (tx_enable),
    .tx_data_out (tx_data_out),
    .tx_valid_out(tx_valid_out),
    .grant_id    (grant_id),
    .busy        (busy),
    .stall_abort (stall_abort),
    .frame_count (frame_count)
  );

  always #5 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;

  // Requester model: remaining frames, frame length, current beat, frame number.
  int rem[N], flen[N], beat[N], fno[N];
  bit hold[N], urg[N];
  logic [N-1:0] acc;
  logic         busy_prev;
  logic [W-1:0] exp_data[$];
  logic [2:0]   exp_grant[$];
  logic [14:0]  pattern;

  task automatic check(input string tag, input logic [169:0] obs, input logic [169:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int i, input int f, input int b);
    return {16'hDEAD, 64'h0, 8'(f), 8'(b), 32'(i + 1)};
  endfunction

  task automatic set_frames(input int i, input int n, input int len);
    rem[i] = n; flen[i] = len; beat[i] = 0; fno[i] = 0; hold[i] = 1'b0; urg[i] = 1'b0;
  endtask

  task automatic push_frame(input int i, input int f, input int len);
    for (int b = 0; b < len; b++) exp_data.push_back(mk(i, f, b));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (rem[i] > 0) && !hold[i];
      req_last[i]           = (beat[i] == flen[i] - 1);
      req_urgent[i]         = urg[i];
      req_data[i*W +: W]    = mk(i, fno[i], beat[i]);
    end
  endtask

  task automatic monitor();
    logic [2:0]   eg;
    logic [W-1:0] ed;
    if (busy && !busy_prev) begin
      checks++;
      assert (exp_grant.size() != 0) else begin
        errors++;
        $error("FAIL grant_queue observed=grant %0d expected=none", grant_id);
      end
      if (exp_grant.size() != 0) begin
        eg = exp_grant.pop_front();
        check("grant_id", grant_id, eg);
      end
    end
    busy_prev = busy;
    if (tx_valid_out) begin
      checks++;
      assert (exp_data.size() != 0) else begin
        errors++;
        $error("FAIL data_queue observed=%0h expected=none", tx_data_out);
      end
      if (exp_data.size() != 0) begin
        ed = exp_data.pop_front();
        check("tx_data", tx_data_out, ed);
      end
    end
    check("valid_latency", tx_valid_out, |acc);
  endtask

  // One clock: capture handshakes, advance the model after the edge, sample at negedge.
  task automatic tick();
    #1 acc = req_valid & req_ready;
    @(posedge tx_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (beat[i] == flen[i] - 1) begin
          beat[i] = 0; fno[i]++; rem[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
    @(negedge tx_clk);
    monitor();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_beat(input int i, input int b, input string tag);
    int n = 0;
    while (beat[i] != b && n < 20) begin
      tick();
      n++;
    end
    check(tag, 170'(beat[i]), 170'(b));
  endtask

  task automatic drain(input string tag);
    check({tag, "_data_left"}, 170'(exp_data.size()), 170'd0);
    check({tag, "_grant_left"}, 170'(exp_grant.size()), 170'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; flen[i] = 1; beat[i] = 0; fno[i] = 0; hold[i] = 1'b0; urg[i] = 1'b0;
    end
    acc = '0;
    busy_prev = 1'b0;
    tx_enable = 1'b1;
    reset = 1'b1;
    drive();
    #2;
    check("reset_outputs", {tx_data_out, tx_valid_out, grant_id, busy, stall_abort, frame_count, req_ready}, '0);
    @(negedge tx_clk);
    @(negedge tx_clk);
    reset = 1'b0;

    // Round-robin: continuous 2-beat frames from all requesters.
    set_frames(0, 2, 2);
    for (int i = 1; i < N; i++) set_frames(i, 1, 2);
    exp_grant.push_back(3'd0); exp_grant.push_back(3'd1); exp_grant.push_back(3'd2);
    exp_grant.push_back(3'd3); exp_grant.push_back(3'd0);
    push_frame(0, 0, 2); push_frame(1, 0, 2); push_frame(2, 0, 2); push_frame(3, 0, 2); push_frame(0, 1, 2);
    drive();
    pattern = '0;
    for (int k = 0; k < 15; k++) begin
      tick();
      pattern = {pattern[13:0], tx_valid_out};
    end
    check("rr_valid_pattern", pattern, 15'b011011011011011);
    tick();
    check("rr_frame_count", frame_count, 32'd5);
    drain("rr");

    // Urgent requester 3 appears mid-frame; frame from 1 completes first, then 3, then 0.
    set_frames(1, 1, 4);
    exp_grant.push_back(3'd1);
    push_frame(1, 0, 4);
    drive();
    wait_beat(1, 2, "urg_progress");
    set_frames(3, 1, 1); urg[3] = 1'b1;
    set_frames(0, 1, 1);
    exp_grant.push_back(3'd3); exp_grant.push_back(3'd0);
    push_frame(3, 0, 1); push_frame(0, 0, 1);
    drive();
    run(8);
    check("urg_frame_count", frame_count, 32'd8);
    drain("urg");

    // Stall abort: one beat then silence; abort 16 cycles after the last beat edge.
    set_frames(2, 1, 2);
    exp_grant.push_back(3'd2);
    push_frame(2, 0, 2);
    drive();
    wait_beat(2, 1, "stall_progress");
    hold[2] = 1'b1;
    drive();
    for (int j = 1; j <= 17; j++) begin
      tick();
      check($sformatf("stall_abort_c%0d", j), stall_abort, (j == 16));
      check($sformatf("stall_busy_c%0d", j), busy, (j < 16));
    end
    check("stall_frame_count", frame_count, 32'd8);
    hold[2] = 1'b0;
    exp_grant.push_back(3'd2);
    drive();
    run(4);
    check("stall_rearb_count", frame_count, 32'd9);
    drain("stall");

    // Link pause: enable low for 20 cycles mid-frame, requester idle too.
    set_frames(0, 1, 3);
    exp_grant.push_back(3'd0);
    push_frame(0, 0, 3);
    drive();
    wait_beat(0, 1, "pause_progress");
    tx_enable = 1'b0;
    hold[0] = 1'b1;
    drive();
    for (int j = 0; j < 20; j++) begin
      tick();
      check($sformatf("pause_c%0d", j), {|req_ready, stall_abort, tx_valid_out, busy}, 4'b0001);
    end
    tx_enable = 1'b1;
    hold[0] = 1'b0;
    drive();
    run(5);
    check("pause_frame_count", frame_count, 32'd10);
    drain("pause");

    // Reset during beat 3 of a 5-beat frame from requester 2.
    set_frames(2, 1, 5);
    exp_grant.push_back(3'd2);
    exp_data.push_back(mk(2, 0, 0)); exp_data.push_back(mk(2, 0, 1));
    drive();
    wait_beat(2, 2, "rst_progress");
    #2 reset = 1'b1;
    #1;
    check("reset_mid_frame", {tx_data_out, tx_valid_out, grant_id, busy, stall_abort, frame_count, req_ready}, '0);
    @(negedge tx_clk);
    @(negedge tx_clk);
    reset = 1'b0;
    busy_prev = 1'b0;
    acc = '0;
    rem[2] = 0;
    set_frames(1, 1, 1);
    set_frames(3, 1, 1);
    exp_grant.push_back(3'd1); exp_grant.push_back(3'd3);
    push_frame(1, 0, 1); push_frame(3, 0, 1);
    drive();
    run(6);
    check("rst_frame_count", frame_count, 32'd2);
    drain("rst");

    // Data integrity: single-beat frames from requesters 0 and 1.
    set_frames(0, 1, 1);
    set_frames(1, 1, 1);
    exp_grant.push_back(3'd0); exp_grant.push_back(3'd1);
    exp_data.push_back(128'hDEAD_0000_0000_0000_0000_0000_0000_0001);
    exp_data.push_back(128'hDEAD_0000_0000_0000_0000_0000_0000_0002);
    drive();
    run(6);
    check("data_frame_count", frame_count, 32'd4);
    check("data_idle", {busy, tx_valid_out}, 2'b00);
    drain("data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mg_tx_arbiter.md
# mg_tx_arbiter

Frame-level arbiter that shares the single 128-bit multi-gigabit transceiver TX path among several order-entry requesters (e.g. new-order, cancel, heartbeat engines). It grants one requester at a time and holds the grant for a whole multi-beat frame. Urgent requesters win over normal ones, with round-robin fairness inside each class. It drives the transceiver's `tx_data_in`/`tx_valid_in` through one register stage and releases the lock if a granted requester stalls mid-frame.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 128: beat width; must match the transceiver data width.
- `STALL_MAX`, 15: consecutive enabled stall cycles tolerated mid-frame before the lock is forcibly released; 1..255.
- `tx_clk` in 1: transceiver TX clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_data` in NUM_REQ*DATA_W: beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_valid` in NUM_REQ: per-requester beat valid.
- `req_last` in NUM_REQ: final beat of the frame, qualified by valid.
- `req_urgent` in NUM_REQ: urgent class flag; sampled only at grant time.
- `req_ready` out NUM_REQ: per-requester beat accept.
- `tx_enable` in 1: link up / not paused; when low, no beat is accepted and no grant is made.
- `tx_data_out` out DATA_W: to transceiver `tx_data_in`.
- `tx_valid_out` out 1: to transceiver `tx_valid_in`.
- `grant_id` out 3: index of the locked requester; valid while `busy` is high.
- `busy` out 1: the arbiter is in LOCK.
- `stall_abort` out 1: one-cycle pulse when the lock is released by the stall timeout.
- `frame_count` out 32: completed frames (last beat sent); wraps modulo 2^32.

## Operation
- States: IDLE, LOCK.
- **IDLE:**
  - All `req_ready` are 0.
  - If `tx_enable` is 1 and any `req_valid` is 1, pick a winner and go to LOCK with `grant_id` set to the winner.
  - Winner selection:
    - If any valid requester has `req_urgent` = 1, pick among the urgent ones only; otherwise pick among all valid requesters.
    - Within the chosen set, pick the first index at or after `rr_ptr`, searching upward and wrapping.
  - On each grant, `rr_ptr` becomes (winner+1) mod NUM_REQ.
- **LOCK:**
  - `req_ready[grant_id]` = `tx_enable`; all other ready bits are 0 (combinational).
  - A beat is accepted when `req_valid[g]` & `req_ready[g]`.
  - Accepted beat with `req_last` = 1: increment `frame_count`, go to IDLE.
  - Stall counter:
    - Cleared on grant and on every accepted beat.
    - Incremented on each cycle with `tx_enable` = 1 and `req_valid[g]` = 0.
    - Frozen while `tx_enable` = 0.
  - When the stall counter reaches STALL_MAX: pulse `stall_abort` the next cycle, go to IDLE, leave `frame_count` unchanged. Any later beats from that requester re-arbitrate as a new frame.
- Output register, updated every cycle:
  - On an accepted beat: `tx_valid_out` <= 1 and `tx_data_out` <= `req_data[g]`.
  - Otherwise: `tx_valid_out` <= 0; `tx_data_out` holds its value.
- `tx_enable` falling mid-frame only pauses the frame; the lock is kept.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; `rr_ptr` = 0; stall counter = 0.
  - All outputs go to 0: `tx_data_out`, `tx_valid_out`, `grant_id`, `busy`, `stall_abort`, `frame_count`, `req_ready`.
  - A partially sent frame is dropped with no abort pulse.

## Timing
- Grant latency: a request seen in IDLE at edge N gives `busy` = 1 and ready after edge N, so the first beat can be accepted in cycle N+1.
- Inter-frame bubble: exactly one cycle (the IDLE cycle) between the last beat of one frame and the first beat of the next.
- Data latency: a beat accepted in cycle k appears on `tx_data_out`/`tx_valid_out` after edge k. The transceiver adds one more stage, so requester to `mg_tx_data` is 2 cycles.
- Single-beat frames (`req_valid` & `req_last` on the first beat) are legal: LOCK lasts 1 cycle.
- Abort timing: the stall counter reaches STALL_MAX at edge m; `stall_abort` is high during cycle m+1; the next grant is no earlier than edge m+1.
- `req_urgent` changing during LOCK has no effect on the current frame.

## Test plan
- **Round-robin:** all 4 requesters send continuous 2-beat frames, no urgent -> grant order 0,1,2,3,0; `tx_valid_out` pattern 1,1,0 repeating; `frame_count` = 5 after 5 frames.
- **Urgent preemption at boundary:** requester 1 sends a 4-beat frame; requester 3 raises valid+urgent during beat 2 and requester 0 is valid (normal) -> frame 1 completes intact, next grant is 3, then 0.
- **Stall abort:** STALL_MAX = 15; requester 2 sends 1 beat, then drops valid with `tx_enable` = 1 -> `stall_abort` pulses once 16 cycles after the last beat edge; `frame_count` is unchanged; `busy` = 0.
- **Link pause:** `tx_enable` is held low for 20 cycles mid-frame -> no `req_ready`, no `stall_abort`, `tx_valid_out` = 0; the frame resumes and completes when enable returns.
- **Reset mid-frame:** assert `reset` during beat 3 of a 5-beat frame -> all outputs read 0 immediately; after release, first grant goes to the lowest-indexed valid requester (`rr_ptr` = 0).
- **Data integrity:** single-beat frames with data 128'hDEAD..0001 from requester 0 and ..0002 from requester 1 -> values appear on `tx_data_out` one cycle after acceptance, in grant order, with no duplication.
